// File: rtl/ula_seq.sv
// Sequential WIDTH-bit ALU with start/done handshake, registered result and flags.
// Define ULA_DIV_EN to compile in the multi-cycle restoring divider.
module ula_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         opcode,
   output logic [2*WIDTH-1:0] s,
   output logic               busy,
   output logic               done,
   output logic               zero,
   output logic               ovf,
   output logic               err
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [W2-1:0]    s_q, s_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic [W2-1:0]    work_q, work_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ULA_DIV_EN
   logic             is_div_q, is_div_d;
`endif

   // single-cycle datapath, evaluated on the live inputs at the accepting edge
   logic [WIDTH:0]   sum, diff, mul_sum;
   logic [WIDTH-1:0] shamt, shl;
   logic [W2-1:0]    sc_s, mul_next, step_next;
   logic             sc_ovf, sc_err, sc_multi, accept;
`ifdef ULA_DIV_EN
   logic [WIDTH:0]   div_tmp, div_diff;
   logic             div_ge;
   logic [W2-1:0]    div_next;
`endif

   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} - {1'b0, b};
      shamt    = b % WIDTH_V;
      shl      = a << shamt;
      sc_s     = '0;
      sc_ovf   = 1'b0;
      sc_err   = 1'b0;
      sc_multi = 1'b0;
      case (opcode)
         OP_ADD: begin
            sc_s   = W2'(sum);
            sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_s   = W2'(diff);
            sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: sc_s = W2'(a & b);
         OP_OR:  sc_s = W2'(a | b);
         OP_XOR: sc_s = W2'(a ^ b);
         OP_SHL: sc_s = W2'(shl);
         OP_MUL: sc_multi = 1'b1;
         default: begin
`ifdef ULA_DIV_EN
            if (b == '0) begin
               sc_s   = {a, {WIDTH{1'b1}}};
               sc_err = 1'b1;
            end else begin
               sc_multi = 1'b1;
            end
`else
            sc_err = 1'b1;
`endif
         end
      endcase
   end

   // Shift-add: {acc, multiplier} shifts right, acc gains the multiplicand on a 1 bit.
   always_comb begin
      mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, work_q[WIDTH-1:1]};
`ifdef ULA_DIV_EN
      // Restoring: {remainder, dividend/quotient} shifts left, quotient bit enters at LSB.
      div_tmp   = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
      div_diff  = div_tmp - {1'b0, opnd_q};
      div_ge    = (div_tmp >= {1'b0, opnd_q});
      div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                   work_q[WIDTH-2:0], div_ge};
      step_next = is_div_q ? div_next : mul_next;
`else
      step_next = mul_next;
`endif
   end

   assign accept = start && (state_q != ST_RUN);

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      work_d  = work_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
`ifdef ULA_DIV_EN
      is_div_d = is_div_q;
`endif
      case (state_q)
         ST_RUN: begin
            work_d = step_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               s_d     = step_next;
               zero_d  = (step_next == '0);
               ovf_d   = 1'b0;
               err_d   = 1'b0;
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               if (sc_multi) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
`ifdef ULA_DIV_EN
                  is_div_d = opcode[0];
                  work_d   = {{WIDTH{1'b0}}, (opcode[0] ? a : b)};
                  opnd_d   = opcode[0] ? b : a;
`else
                  work_d   = {{WIDTH{1'b0}}, b};
                  opnd_d   = a;
`endif
               end else begin
                  s_d     = sc_s;
                  zero_d  = (sc_s == '0);
                  ovf_d   = sc_ovf;
                  err_d   = sc_err;
                  state_d = ST_DONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         work_q  <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
`ifdef ULA_DIV_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         work_q  <= work_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
`ifdef ULA_DIV_EN
         is_div_q <= is_div_d;
`endif
      end
   end

   assign s    = s_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;
   assign err  = err_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ula_seq.sv
// Randomised self-checking bench for ula_seq (WIDTH = 8) against an arithmetic reference model.
module tb_ula_seq;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [2:0]     opcode = '0;
   logic [2*W-1:0] s;
   logic           busy, done, zero, ovf, err;

   int total = 0;
   int bad   = 0;

   ula_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .opcode(opcode),
      .s(s), .busy(busy), .done(done), .zero(zero), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic int to_signed8(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   task automatic model(input int op, input int va, input int vb,
                        output int es, output int eovf, output int eerr, output int elat);
      int r;
      es = 0; eovf = 0; eerr = 0; elat = 0;
      case (op)
         0: begin
            es = va + vb;
            r  = to_signed8(va) + to_signed8(vb);
            eovf = (r > 127 || r < -128) ? 1 : 0;
         end
         1: begin
            es = ((va - vb) & 255) + ((va < vb) ? 256 : 0);
            r  = to_signed8(va) - to_signed8(vb);
            eovf = (r > 127 || r < -128) ? 1 : 0;
         end
         2: es = va & vb;
         3: es = va | vb;
         4: es = va ^ vb;
         5: es = (va << (vb % W)) & 255;
         6: begin es = va * vb; elat = W; end
         default: begin
`ifdef ULA_DIV_EN
            if (vb == 0) begin
               es = va * 256 + 255; eerr = 1;
            end else begin
               es = (va % vb) * 256 + (va / vb); elat = W;
            end
`else
            es = 0; eerr = 1;
`endif
         end
      endcase
   endtask

   // Issues one op from just after a clock edge; noise=1 pulses ignored starts while busy.
   task automatic do_op(input int op, input int va, input int vb, input bit noise);
      int es, eovf, eerr, elat, n, busy_bad;
      model(op, va, vb, es, eovf, eerr, elat);
      start = 1'b1; opcode = 3'(op); a = 8'(va); b = 8'(vb);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; busy_bad = 0;
      while (!done && n < 40) begin
         if (busy !== 1'b1) busy_bad = 1;
         if (noise && $urandom_range(0, 1) == 1) begin
            start = 1'b1; opcode = 3'b000; a = 8'($urandom); b = 8'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      $display("op=%0d a=%02h b=%02h s=%04h zero=%0b ovf=%0b err=%0b lat=%0d",
               op, va, vb, s, zero, ovf, err, n);
      check_val("latency", n, elat);
      check_val("busy_during", busy_bad, 0);
      check_val("done", done, 1);
      check_val("busy_at_done", busy, 0);
      check_val("s", s, es);
      check_val("zero", zero, (es == 0) ? 1 : 0);
      check_val("ovf", ovf, eovf);
      check_val("err", err, eerr);
      @(posedge clk); #1;
      check_val("done_pulse", done, 0);
      check_val("s_hold", s, es);
   endtask

   initial begin
      int es, eovf, eerr, elat, seen;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_s", s, 0);
      check_val("rst_flags", {busy, done, zero, ovf, err}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(0, 8'hFF, 8'h01, 0);
      do_op(0, 8'h7F, 8'h01, 0);
      do_op(1, 8'h01, 8'h02, 0);
      do_op(1, 8'h80, 8'h01, 0);
      do_op(4, 8'h5A, 8'h5A, 0);
      do_op(6, 8'hFF, 8'hFF, 1);
      do_op(7, 200, 7, 1);
      do_op(7, 8'h33, 0, 0);
      do_op(5, 8'h81, 9, 0);

      // Reset mid-multiply: immediate clear, no done afterwards.
      do_op(0, 8'h12, 8'h34, 0);
      start = 1'b1; opcode = 3'b110; a = 8'hAB; b = 8'hCD;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b0; #1;
      check_val("abort_s", s, 0);
      check_val("abort_flags", {busy, done, zero, ovf, err}, 0);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen = 1;
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (W + 2) begin
         @(posedge clk); #1;
         if (done) seen = 1;
      end
      check_val("abort_no_done", seen, 0);
      do_op(0, 3, 4, 0);

      // Back-to-back: SHL issued in the ADD done cycle.
      start = 1'b1; opcode = 3'b000; a = 8'h10; b = 8'h20;
      @(posedge clk); #1;
      opcode = 3'b101; a = 8'h81; b = 8'd9;
      check_val("b2b_done1", done, 1);
      check_val("b2b_s1", s, 16'h0030);
      @(posedge clk); #1;
      start = 1'b0;
      $display("op=b2b a=81 b=09 s=%04h done=%0b", s, done);
      check_val("b2b_done2", done, 1);
      check_val("b2b_s2", s, 16'h0002);
      @(posedge clk); #1;
      check_val("b2b_end", done, 0);

      for (int i = 0; i < 120; i++) begin
         int op, va, vb;
         op = $urandom_range(0, 7);
         va = $urandom_range(0, 255);
         vb = (i % 10 == 0) ? 0 : $urandom_range(0, 255);
         do_op(op, va, vb, $urandom_range(0, 1) == 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, sequential successor of the 8-bit ALU. It is a WIDTH-bit ALU with a start/done handshake, registered result and flags. It adds multi-cycle shift-add multiply and optional restoring divide alongside the single-cycle ops, and sits between the operand registers and the result bus of the datapath.

## Interface
- WIDTH, 8, operand width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  operand A (unsigned unless noted)
- b  in  WIDTH  operand B
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV
- s  out  2*WIDTH  registered result
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse, s/flags valid and updated
- zero  out  1  s == 0 (all 2*WIDTH bits)
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- err  out  1  DIV by zero, or DIV issued while not compiled in

## Operation
- States: IDLE, RUN, DONE. The DONE state lasts one cycle and behaves as IDLE for accepting start.
- a, b and opcode are captured on the accepting edge. Later input changes do not affect the result.
- ADD: s[WIDTH:0] = a + b, where s[WIDTH] is the carry. Upper bits are 0.
- SUB: s[WIDTH-1:0] = a − b mod 2^WIDTH, and s[WIDTH] = borrow (a < b). Upper bits are 0.
- AND/OR/XOR: bitwise, in s[WIDTH-1:0]. Upper bits are 0.
- SHL: a << (b mod WIDTH), in s[WIDTH-1:0]. Bits shifted out are discarded.
- MUL: unsigned a × b, full 2*WIDTH product, one shift-add step per cycle, WIDTH steps.
- DIV: restoring, one step per cycle, WIDTH steps. s[WIDTH-1:0] = quotient, s[2W-1:W] = remainder.
- DIV with b = 0: single-cycle; s = {a, all-ones quotient}; err = 1.
- err = 0 for all other completed ops. Flags (zero, ovf, err) update only together with s at done.
- s and flags hold their values between operations.
- start while busy = 1: ignored, with no effect on the op in flight.

## Timing
- Reset (async assert): s = 0, busy = 0, done = 0, zero = 0, ovf = 0, err = 0, state IDLE.
  - Reset during RUN aborts the operation; no done is produced.
  - The first start after rst_n rises is accepted normally.
- Accept edge E means the rising edge where start = 1 and busy = 0.
- Single-cycle ops (including DIV-by-zero): s/flags are written at edge E; done = 1 for the cycle after E; busy stays 0.
- MUL/DIV: busy = 1 after edges E … E+WIDTH−1.
  - At edge E+WIDTH: s/flags written, busy = 0, done = 1 for one cycle.
  - Latency is WIDTH cycles.
- Back-to-back: start may be high in the done cycle and is accepted at that edge (busy = 0). Throughput is one single-cycle op per clock.

## Configuration
- ULA_DIV_EN defined: DIV datapath compiled in, behaving as described above.
- ULA_DIV_EN undefined: no divider logic. Opcode 111 completes single-cycle with s = 0, zero = 1, err = 1.

## Test plan
All scenarios use WIDTH = 8.
1. ADD a=0xFF, b=0x01 -> s=0x0100, zero=0, ovf=0, done one cycle after the accept edge, busy never high. Then ADD a=0x7F, b=0x01 -> s=0x0080, ovf=1.
2. SUB a=0x01, b=0x02 -> s=0x01FF, err=0. SUB a=0x80, b=0x01 -> s=0x007F, ovf=1. XOR a=0x5A, b=0x5A -> s=0, zero=1.
3. MUL a=0xFF, b=0xFF -> busy high exactly 8 cycles, done after edge E+8, s=0xFE01. During busy, change a/b and pulse start with opcode ADD -> ignored, result unchanged.
4. DIV (ULA_DIV_EN) a=200, b=7 -> s=0x041C (remainder 4, quotient 28) after 8 cycles. DIV a=0x33, b=0 -> one cycle, s=0x33FF, err=1. Without ULA_DIV_EN: DIV -> s=0, zero=1, err=1, one cycle.
5. Start MUL, assert rst_n=0 at cycle 4 -> all outputs 0 immediately, no done. After release, ADD 3+4 -> s=7.
6. Back-to-back: ADD, then SHL a=0x81, b=9 (shift 1) issued in the done cycle -> consecutive done pulses, s=0x0002.
